rename_regfile: RTL and testbench

- Multi-port architectural register file with a per-register busy/ROB-tag table for a dual-issue out-of-order core.
- Decode reads operands, plus the busy bit and ROB tag of any pending producer.
- The ROB renames destinations at dispatch and writes values at commit.
- Successor of the single-port scoreboard regfile. Adds parametrised widths and port counts, same-cycle commit bypass, and branch checkpoints so a mispredict restores the table instead of flushing it.

---
 rtl/rename_regfile_pkg.sv | 27 ++
 rtl/rename_regfile_if.sv | 47 ++++
 rtl/rr_ckpt_bank.sv | 52 +++++
 rtl/rename_regfile.sv | 107 ++++++++++
 tb/tb_rename_regfile.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared types and helpers for the rename register file and its checkpoint bank.
// The ROB tag width is fixed here because the table entry type is shared by every block.
package rename_regfile_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned ROB_W    = 4;

   typedef struct packed {
      logic             busy;
      logic [ROB_W-1:0] tag;
   } ent_t;

   function automatic int unsigned addr_w(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Index of the highest set bit: the youngest port among the hits.
   function automatic int unsigned youngest(logic [7:0] hits);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (hits[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rename_regfile_if.sv
// Decode/rename/commit/checkpoint bus of the rename register file.
interface rename_regfile_if
   import rename_regfile_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREG  = 32,
   parameter int unsigned NRP   = 4,
   parameter int unsigned NRN   = 2,
   parameter int unsigned NCM   = 2,
   parameter int unsigned NCKPT = 4
) ();
   localparam int unsigned AW = addr_w(NREG);
   localparam int unsigned CW = addr_w(NCKPT);

   logic                  rdy;
   logic                  flush;
   logic [NRP*AW-1:0]     rd_addr;
   logic [NRP*XLEN-1:0]   rd_val;
   logic [NRP-1:0]        rd_busy;
   logic [NRP*ROB_W-1:0]  rd_tag;
   logic [NRN-1:0]        ren_en;
   logic [NRN*AW-1:0]     ren_rd;
   logic [NRN*ROB_W-1:0]  ren_tag;
   logic [NCM-1:0]        cm_en;
   logic [NCM*AW-1:0]     cm_rd;
   logic [NCM*ROB_W-1:0]  cm_tag;
   logic [NCM*XLEN-1:0]   cm_val;
   logic                  ck_save;
   logic [CW-1:0]         ck_save_id;
   logic                  ck_restore;
   logic [CW-1:0]         ck_restore_id;

   modport master (
      output rdy, flush, rd_addr, ren_en, ren_rd, ren_tag,
             cm_en, cm_rd, cm_tag, cm_val,
             ck_save, ck_save_id, ck_restore, ck_restore_id,
      input  rd_val, rd_busy, rd_tag
   );

   modport slave (
      input  rdy, flush, rd_addr, ren_en, ren_rd, ren_tag,
             cm_en, cm_rd, cm_tag, cm_val,
             ck_save, ck_save_id, ck_restore, ck_restore_id,
      output rd_val, rd_busy, rd_tag
   );

endinterface

// File: rtl/rr_ckpt_bank.sv
// Branch checkpoint storage for the busy/tag table: save, restore-read, and
// commit tag-match clears broadcast into every slot.
module rr_ckpt_bank
   import rename_regfile_pkg::*;
#(
   parameter int unsigned NREG  = 32,
   parameter int unsigned NCM   = 2,
   parameter int unsigned NCKPT = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned CW    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  save_i,
   input  logic [CW-1:0]         save_id_i,
   input  ent_t [NREG-1:0]       save_img_i,
   input  logic [CW-1:0]         restore_id_i,
   output ent_t [NREG-1:0]       restore_img_o,
   input  logic [NCM-1:0]        clr_en_i,
   input  logic [NCM*AW-1:0]     clr_rd_i,
   input  logic [NCM*ROB_W-1:0]  clr_tag_i
);

   ent_t [NCKPT-1:0][NREG-1:0] slot_q;
   ent_t [NCKPT-1:0][NREG-1:0] slot_d;

   // Clears match against each slot's own pre-edge tag, then a save overwrites its slot.
   always_comb begin
      slot_d = slot_q;
      for (int s = 0; s < NCKPT; s++) begin
         for (int i = 0; i < NCM; i++) begin
            if (clr_en_i[i] && (clr_rd_i[i*AW +: AW] != '0) &&
                (slot_q[s][clr_rd_i[i*AW +: AW]].tag == clr_tag_i[i*ROB_W +: ROB_W])) begin
               slot_d[s][clr_rd_i[i*AW +: AW]].busy = 1'b0;
            end
         end
      end
      if (save_i) slot_d[save_id_i] = save_img_i;
   end

   assign restore_img_o = slot_d[restore_id_i];

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= '0;
      end else if (en_i) begin
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/rename_regfile.sv
// Multi-port architectural register file with busy/ROB-tag rename table,
// same-cycle commit bypass on reads and branch checkpoint restore.
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREG  = 32,
   parameter int unsigned NRP   = 4,
   parameter int unsigned NRN   = 2,
   parameter int unsigned NCM   = 2,
   parameter int unsigned NCKPT = 4
) (
   input logic             clk,
   input logic             rst,
   rename_regfile_if.slave bus
);
   localparam int unsigned AW = addr_w(NREG);
   localparam int unsigned CW = addr_w(NCKPT);

   logic [NREG-1:0][XLEN-1:0] val_q, val_d;
   ent_t [NREG-1:0]           tab_q, tab_d;
   ent_t [NREG-1:0]           tab_clr, tab_ren, rst_img;
   logic                      save_en;

   // Read ports: a committing producer whose tag matches resolves the operand now.
   for (genvar p = 0; p < NRP; p++) begin : g_rd
      logic [AW-1:0]  a;
      ent_t           e;
      logic [NCM-1:0] hit;

      assign a = bus.rd_addr[p*AW +: AW];
      assign e = tab_q[a];

      for (genvar i = 0; i < NCM; i++) begin : g_hit
         assign hit[i] = bus.cm_en[i] && e.busy &&
                         (bus.cm_rd[i*AW +: AW] == a) &&
                         (bus.cm_tag[i*ROB_W +: ROB_W] == e.tag);
      end

      assign bus.rd_val[p*XLEN +: XLEN] = (|hit) ? bus.cm_val[youngest(8'(hit))*XLEN +: XLEN]
                                                 : val_q[a];
      assign bus.rd_busy[p]               = e.busy && !(|hit);
      assign bus.rd_tag[p*ROB_W +: ROB_W] = e.tag;
   end

   // Next state: commits, then renames on top; flush and restore replace the table.
   always_comb begin
      val_d   = val_q;
      tab_clr = tab_q;
      for (int i = 0; i < NCM; i++) begin
         if (bus.cm_en[i] && (bus.cm_rd[i*AW +: AW] != '0)) begin
            val_d[bus.cm_rd[i*AW +: AW]] = bus.cm_val[i*XLEN +: XLEN];
            if (tab_q[bus.cm_rd[i*AW +: AW]].tag == bus.cm_tag[i*ROB_W +: ROB_W]) begin
               tab_clr[bus.cm_rd[i*AW +: AW]].busy = 1'b0;
            end
         end
      end

      tab_ren = tab_clr;
      for (int j = 0; j < NRN; j++) begin
         if (bus.ren_en[j] && (bus.ren_rd[j*AW +: AW] != '0)) begin
            tab_ren[bus.ren_rd[j*AW +: AW]] = '{busy: 1'b1, tag: bus.ren_tag[j*ROB_W +: ROB_W]};
         end
      end

      tab_d = tab_ren;
      if (bus.flush) begin
         tab_d = tab_q;
         for (int r = 0; r < NREG; r++) tab_d[r].busy = 1'b0;
      end else if (bus.ck_restore) begin
         tab_d = rst_img;
      end
   end

   assign save_en = bus.ck_save && !bus.flush && !bus.ck_restore;

   rr_ckpt_bank #(
      .NREG  (NREG),
      .NCM   (NCM),
      .NCKPT (NCKPT),
      .AW    (AW),
      .CW    (CW)
   ) u_ckpt (
      .clk           (clk),
      .rst           (rst),
      .en_i          (bus.rdy),
      .save_i        (save_en),
      .save_id_i     (bus.ck_save_id),
      .save_img_i    (tab_ren),
      .restore_id_i  (bus.ck_restore_id),
      .restore_img_o (rst_img),
      .clr_en_i      (bus.cm_en),
      .clr_rd_i      (bus.cm_rd),
      .clr_tag_i     (bus.cm_tag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
         tab_q <= '0;
      end else if (bus.rdy) begin
         val_q <= val_d;
         tab_q <= tab_d;
      end
   end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: reads, rename/commit, bypass, checkpoints, flush, rdy, x0.
module tb_rename_regfile;

   logic clk;
   logic rst;
   int   checks;
   int   passed;

   rename_regfile_if bus ();

   rename_regfile dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_in();
      bus.rdy           = 1'b1;
      bus.flush         = 1'b0;
      bus.ren_en        = '0;
      bus.ren_rd        = '0;
      bus.ren_tag       = '0;
      bus.cm_en         = '0;
      bus.cm_rd         = '0;
      bus.cm_tag        = '0;
      bus.cm_val        = '0;
      bus.ck_save       = 1'b0;
      bus.ck_save_id    = '0;
      bus.ck_restore    = 1'b0;
      bus.ck_restore_id = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   task automatic set_rd(int p, int a);
      bus.rd_addr[p*5 +: 5] = 5'(a);
   endtask

   task automatic ren(int p, int rd, int tag);
      bus.ren_en[p]          = 1'b1;
      bus.ren_rd[p*5 +: 5]   = 5'(rd);
      bus.ren_tag[p*4 +: 4]  = 4'(tag);
   endtask

   task automatic cmt(int p, int rd, int tag, logic [31:0] v);
      bus.cm_en[p]            = 1'b1;
      bus.cm_rd[p*5 +: 5]     = 5'(rd);
      bus.cm_tag[p*4 +: 4]    = 4'(tag);
      bus.cm_val[p*32 +: 32]  = v;
   endtask

   task automatic test_reset();
      clr_in();
      bus.rd_addr = '0;
      rst = 1'b1;
      bus.rdy = 1'b0;
      ren(0, 5, 3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      clr_in();
      for (int p = 0; p < 4; p++) set_rd(p, 5);
      #1;
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (bus.rd_val[p*32 +: 32] !== 32'h0)
            $display("FAIL reset_val port%0d got %h want 0", p, bus.rd_val[p*32 +: 32]);
         else passed++;
         checks++;
         if (bus.rd_busy[p] !== 1'b0)
            $display("FAIL reset_busy port%0d got %b want 0", p, bus.rd_busy[p]);
         else passed++;
      end
   endtask

   task automatic test_rename_commit();
      ren(0, 5, 3);
      step();
      set_rd(0, 5);
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0]} !== 5'b1_0011)
         $display("FAIL ren_busy_tag got %b/%h want 1/3", bus.rd_busy[0], bus.rd_tag[3:0]);
      else passed++;
      cmt(0, 5, 3, 32'hDEADBEEF);
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_val[31:0]} !== {1'b0, 32'hDEADBEEF})
         $display("FAIL bypass got %b/%h want 0/deadbeef", bus.rd_busy[0], bus.rd_val[31:0]);
      else passed++;
      step();
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_val[31:0]} !== {1'b0, 32'hDEADBEEF})
         $display("FAIL commit_stored got %b/%h want 0/deadbeef", bus.rd_busy[0], bus.rd_val[31:0]);
      else passed++;
   endtask

   task automatic test_stale_commit();
      ren(0, 7, 2);
      step();
      ren(0, 7, 9);
      step();
      set_rd(0, 7);
      cmt(0, 7, 2, 32'h11);
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_val[31:0]} !== {1'b1, 32'h0})
         $display("FAIL stale_no_bypass got %b/%h want 1/0", bus.rd_busy[0], bus.rd_val[31:0]);
      else passed++;
      step();
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]} !== {1'b1, 4'h9, 32'h11})
         $display("FAIL stale_commit got %b/%h/%h want 1/9/11",
                  bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]);
      else passed++;
   endtask

   task automatic test_dual_port();
      ren(0, 4, 1);
      ren(1, 4, 6);
      step();
      set_rd(1, 4);
      #1;
      checks++;
      if ({bus.rd_busy[1], bus.rd_tag[7:4]} !== 5'b1_0110)
         $display("FAIL dual_ren got %b/%h want 1/6", bus.rd_busy[1], bus.rd_tag[7:4]);
      else passed++;
      cmt(0, 4, 6, 32'hA);
      cmt(1, 4, 6, 32'hB);
      #1;
      checks++;
      if ({bus.rd_busy[1], bus.rd_val[63:32]} !== {1'b0, 32'hB})
         $display("FAIL dual_bypass got %b/%h want 0/b", bus.rd_busy[1], bus.rd_val[63:32]);
      else passed++;
      step();
      #1;
      checks++;
      if ({bus.rd_busy[1], bus.rd_val[63:32]} !== {1'b0, 32'hB})
         $display("FAIL dual_commit got %b/%h want 0/b", bus.rd_busy[1], bus.rd_val[63:32]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      ren(0, 9, 2);
      step();
      ren(0, 9, 5);
      cmt(1, 9, 2, 32'h77);
      step();
      set_rd(2, 9);
      #1;
      checks++;
      if ({bus.rd_busy[2], bus.rd_tag[11:8], bus.rd_val[95:64]} !== {1'b1, 4'h5, 32'h77})
         $display("FAIL ren_cm_same got %b/%h/%h want 1/5/77",
                  bus.rd_busy[2], bus.rd_tag[11:8], bus.rd_val[95:64]);
      else passed++;
   endtask

   task automatic test_checkpoint();
      ren(0, 1, 4);
      bus.ck_save    = 1'b1;
      bus.ck_save_id = 2'd2;
      step();
      ren(0, 2, 5);
      ren(1, 1, 7);
      step();
      set_rd(0, 1);
      set_rd(1, 2);
      set_rd(2, 3);
      #1;
      checks++;
      if ({bus.rd_busy[1:0], bus.rd_tag[7:0]} !== {2'b11, 8'h57})
         $display("FAIL ck_live got %b/%h want 11/57", bus.rd_busy[1:0], bus.rd_tag[7:0]);
      else passed++;
      cmt(0, 1, 4, 32'h55);
      step();
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]} !== {1'b1, 4'h7, 32'h55})
         $display("FAIL ck_old_commit got %b/%h/%h want 1/7/55",
                  bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]);
      else passed++;
      bus.ck_restore    = 1'b1;
      bus.ck_restore_id = 2'd2;
      ren(0, 3, 8);
      step();
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]} !== {1'b0, 4'h4, 32'h55})
         $display("FAIL ck_restore_x1 got %b/%h/%h want 0/4/55",
                  bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]);
      else passed++;
      checks++;
      if (bus.rd_busy[2:1] !== 2'b00)
         $display("FAIL ck_restore_x2x3 got %b want 00", bus.rd_busy[2:1]);
      else passed++;
      ren(0, 6, 1);
      step();
      bus.ck_restore    = 1'b1;
      bus.ck_restore_id = 2'd3;
      step();
      set_rd(3, 6);
      #1;
      checks++;
      if (bus.rd_busy[3] !== 1'b0)
         $display("FAIL ck_unsaved got %b want 0", bus.rd_busy[3]);
      else passed++;
   endtask

   task automatic test_flush();
      bus.flush = 1'b1;
      step();
      ren(0, 1, 1);
      bus.ck_save    = 1'b1;
      bus.ck_save_id = 2'd0;
      step();
      for (int r = 1; r < 32; r += 2) begin
         ren(0, r, r);
         if (r + 1 < 32) ren(1, r + 1, r + 1);
         step();
      end
      set_rd(0, 31);
      set_rd(1, 16);
      #1;
      checks++;
      if ({bus.rd_busy[1:0], bus.rd_tag[7:0]} !== {2'b11, 8'h0F})
         $display("FAIL fl_pending got %b/%h want 11/0f", bus.rd_busy[1:0], bus.rd_tag[7:0]);
      else passed++;
      bus.flush      = 1'b1;
      bus.ck_save    = 1'b1;
      bus.ck_save_id = 2'd0;
      ren(0, 2, 3);
      step();
      for (int r = 1; r < 32; r++) begin
         set_rd(0, r);
         #1;
         checks++;
         if (bus.rd_busy[0] !== 1'b0)
            $display("FAIL fl_clear x%0d got %b want 0", r, bus.rd_busy[0]);
         else passed++;
      end
      bus.ck_restore    = 1'b1;
      bus.ck_restore_id = 2'd0;
      step();
      set_rd(0, 1);
      set_rd(1, 2);
      set_rd(2, 31);
      #1;
      checks++;
      if ({bus.rd_busy[2:0], bus.rd_tag[3:0]} !== {3'b001, 4'h1})
         $display("FAIL fl_save_ignored got %b/%h want 001/1", bus.rd_busy[2:0], bus.rd_tag[3:0]);
      else passed++;
   endtask

   task automatic test_rdy_hold();
      bus.rdy = 1'b0;
      ren(0, 10, 4);
      cmt(0, 1, 1, 32'h99);
      bus.ck_restore    = 1'b1;
      bus.ck_restore_id = 2'd3;
      step();
      set_rd(0, 1);
      set_rd(1, 10);
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]} !== {1'b1, 4'h1, 32'h55})
         $display("FAIL rdy_x1 got %b/%h/%h want 1/1/55",
                  bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]);
      else passed++;
      checks++;
      if (bus.rd_busy[1] !== 1'b0)
         $display("FAIL rdy_x10 got %b want 0", bus.rd_busy[1]);
      else passed++;
   endtask

   task automatic test_x0();
      for (int p = 0; p < 4; p++) set_rd(p, 0);
      ren(0, 0, 1);
      cmt(0, 0, 0, 32'hFF);
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_val[31:0]} !== 33'h0)
         $display("FAIL x0_same_cycle got %b/%h want 0/0", bus.rd_busy[0], bus.rd_val[31:0]);
      else passed++;
      step();
      #1;
      checks++;
      if ({bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]} !== 37'h0)
         $display("FAIL x0_after got %b/%h/%h want 0/0/0",
                  bus.rd_busy[0], bus.rd_tag[3:0], bus.rd_val[31:0]);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst    = 1'b1;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_dual_port();
      test_back_to_back();
      test_checkpoint();
      test_flush();
      test_rdy_hold();
      test_x0();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
